// File: rtl/icache_pkg.sv
// icache_dm shared types and geometry.
// Direct-mapped, one 32-bit word per line.
package icache_pkg;

  localparam int BIT_SIZE = 32;
  localparam int MEM_SIZE = 16;
  localparam int OFF_W    = 2;
  localparam int IDX_W    = 4;
  localparam int TAG_W    = MEM_SIZE - IDX_W - OFF_W;
  localparam int LINES    = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and instruction-memory-side buses
// of the direct-mapped instruction cache.
interface icache_dm_if #(
  parameter int AW = icache_pkg::MEM_SIZE,
  parameter int DW = icache_pkg::BIT_SIZE
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          flush;
  logic [DW-1:0] cpu_instr;
  logic          IC_stall;

  modport master (
    output cpu_req, cpu_addr, flush,
    input  cpu_instr, IC_stall
  );

  modport slave (
    input  cpu_req, cpu_addr, flush,
    output cpu_instr, IC_stall
  );
endinterface

interface im_bus_if #(
  parameter int AW = icache_pkg::MEM_SIZE,
  parameter int DW = icache_pkg::BIT_SIZE
);
  logic [AW-1:0] IM_Address;
  logic          IM_en_Read;
  logic [DW-1:0] Instruction;

  modport master (
    output IM_Address, IM_en_Read,
    input  Instruction
  );

  modport slave (
    input  IM_Address, IM_en_Read,
    output Instruction
  );
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays: async read, one write port,
// synchronous flush that wins over a same-cycle write.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int TW = TAG_W,
  parameter int DW = BIT_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TW-1:0]    rd_tag,
  output logic [DW-1:0]    rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TW-1:0]    wr_tag,
  input  logic [DW-1:0]    wr_data
);

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_ram  [LINES];
  logic [DW-1:0]    data_ram [LINES];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_ram[rd_idx];
  assign rd_data  = data_ram[rd_idx];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Arrays carry no reset; a flushed fill is simply dropped.
  always_ff @(posedge clk) begin
    if (we && !flush && !rst) begin
      tag_ram[wr_idx]  <= wr_tag;
      data_ram[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped I-cache: same-cycle hit, 3-cycle
// stalled single-word refill from IM, hit/miss counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int bit_size = BIT_SIZE,
  parameter int mem_size = MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  cpu,
  im_bus_if.master    im,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TW = mem_size - IDX_W - OFF_W;
  localparam int WW = mem_size - OFF_W;

  state_t               state;
  logic [WW-1:0]        miss_word;
  logic                 im_en;
  logic [mem_size-1:0]  im_addr;

  logic [IDX_W-1:0]     idx;
  logic [TW-1:0]        tag;
  logic [WW-1:0]        word;
  logic                 rd_valid;
  logic [TW-1:0]        rd_tag;
  logic [bit_size-1:0]  rd_data;
  logic                 hit;
  logic                 miss;
  logic                 idle;
  logic                 we;

  assign word = cpu.cpu_addr[mem_size-1:OFF_W];
  assign idx  = word[IDX_W-1:0];
  assign tag  = word[WW-1:IDX_W];

  assign hit  = cpu.cpu_req && rd_valid && (rd_tag == tag);
  assign miss = cpu.cpu_req && !hit;
  assign idle = (state == IDLE);
  assign we   = (state == FILL) && !rst;

  assign cpu.cpu_instr = rd_data;
  assign cpu.IC_stall  = !rst && (!idle || miss);
  assign im.IM_en_Read = im_en;
  assign im.IM_Address = im_addr;

  icache_line_store #(
    .TW (TW),
    .DW (bit_size)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .flush    (cpu.flush),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (we),
    .wr_idx   (miss_word[IDX_W-1:0]),
    .wr_tag   (miss_word[WW-1:IDX_W]),
    .wr_data  (im.Instruction)
  );

  // The replay after FILL is a normal IDLE lookup and counts as a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      miss_word <= '0;
      im_en     <= 1'b0;
      im_addr   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            hit_cnt <= hit_cnt + 32'd1;
          end else if (miss) begin
            miss_cnt  <= miss_cnt + 32'd1;
            miss_word <= word;
            im_en     <= 1'b1;
            im_addr   <= {word, {OFF_W{1'b0}}};
            state     <= REQ;
          end
        end
        REQ: begin
          im_en   <= 1'b0;
          im_addr <= '0;
          state   <= FILL;
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped instruction cache between the pipelined CPU fetch stage and the instruction memory `IM`. It answers fetches in the same cycle on a hit. On a miss it stalls the pipeline through `IC_stall`, fetches one word from `IM` and refills the line. It also keeps hit and miss counters, which the bench uses for hit-rate checks (target > 0.5).

## Interface
- `bit_size`, 32, instruction/data word width
- `mem_size`, 16, byte-address width of `IM_Address`/`cpu_addr`
- `IDX_W`, 4, index bits (16 lines, one word per line)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `cpu_req`  in  1  fetch valid this cycle
- `cpu_addr`  in  mem_size  fetch byte address (PC); bits [1:0] ignored
- `flush`  in  1  invalidate all lines (one-cycle pulse)
- `cpu_instr`  out  bit_size  instruction to decode stage; valid when `IC_stall`=0
- `IC_stall`  out  1  pipeline freeze request
- `IM_Address`  out  mem_size  word-aligned refill byte address
- `IM_en_Read`  out  1  IM read strobe
- `Instruction`  in  bit_size  IM read data, valid one cycle after `IM_en_Read`
- `hit_cnt`  out  32  hits since reset
- `miss_cnt`  out  32  misses since reset

## Operation
- **Address split:** offset=[1:0], index=[IDX_W+1:2], tag=[mem_size-1:IDX_W+2] (10 bits at defaults).
- **Lookup** is combinational. hit = `cpu_req` & `valid[index]` & (`tag_ram[index]`==tag).
- `cpu_instr` = `data_ram[index]` at all times. It is meaningful only on a hit.
- **FSM states:** `IDLE`, `REQ`, `FILL`.
- **IDLE:**
  - hit: `IC_stall`=0, `hit_cnt`+1.
  - miss (`cpu_req` & !hit): `IC_stall`=1, `miss_cnt`+1, latch `cpu_addr` with [1:0] forced to 0 into `miss_addr`, go to REQ.
  - `cpu_req`=0: `IC_stall`=0, no count.
- **REQ:** `IM_en_Read`=1, `IM_Address`=`miss_addr`, `IC_stall`=1. Go to FILL.
- **FILL:** capture `Instruction` into `data_ram[miss idx]`, write `tag_ram`, set valid, `IC_stall`=1. Go to IDLE.
- **Replay:** the re-lookup in IDLE hits. It counts as a hit, so one miss costs exactly one `miss_cnt` and one `hit_cnt`.
- `IM_en_Read`=0 and `IM_Address`=0 outside REQ.
- **Flush:** clears all valid bits at the clock edge.
  - Flush in FILL: the refill write is discarded (line stays invalid). FSM still returns to IDLE, and the replay misses again.
  - Flush in IDLE/REQ: no state change.
- **Counters:** 32-bit, wrap modulo 2^32, no saturation.
- **Arrays:** tag/data arrays are not reset, only the valid bits.

## Timing
- **Reset:** all valid=0, state=IDLE, `hit_cnt`=`miss_cnt`=0, `IM_en_Read`=0, `IM_Address`=0.
- **Outputs during reset:** `IC_stall` is driven 0 while `rst`=1. `cpu_instr` is undefined until the first fill.
- **Hit latency:** 0 cycles (same-cycle `cpu_instr`).
- **Miss penalty:** 3 stalled cycles (IDLE-miss, REQ, FILL). The instruction is delivered in cycle 4.
- **CPU contract:** the CPU holds `cpu_addr`/`cpu_req` stable while `IC_stall`=1. The cache uses `miss_addr`, so a changing `cpu_addr` affects only the replay lookup.
- **Reset mid-miss:** abort to IDLE, no array write, `IM_en_Read` drops the next cycle.
- **Conflict:** addresses 0x0000 and 0x0040 share index 0. Alternating between them misses every time (no thrash protection).

## Structure
- **Package `icache_pkg`:** state enum (`IDLE`/`REQ`/`FILL`) and localparams `OFF_W`=2, `IDX_W`, `TAG_W`=mem_size-IDX_W-2, `LINES`=2**IDX_W.
- **Sub-module `icache_line_store`:** valid/tag/data arrays. Provides an async read port, a single write port and a synchronous flush with write-discard priority.
- **Top `icache_dm`:** FSM, address split, counters, IM interface.

## Test plan
- Reset, then `cpu_req`=1 at `cpu_addr`=0x0014 with IM[5]=0x8C010000:
  - `IC_stall` high for 3 cycles.
  - `IM_en_Read` high exactly 1 cycle with `IM_Address`=0x0014.
  - Cycle 4: `cpu_instr`=0x8C010000, `IC_stall`=0, `miss_cnt`=1, `hit_cnt`=1.
- Re-fetch 0x0014 three times: no stall, `hit_cnt`=4, `miss_cnt`=1, `IM_en_Read` stays 0.
- Fetch 0x0000, then 0x0040, then 0x0000 (conflict): 3 misses, `miss_cnt`=3, each refill reads the correct IM word.
- Sequential loop 0x0000–0x003C run twice: first pass 16 misses, second pass 16 hits with zero stalls; hit rate > 0.5.
- `flush` asserted in the FILL cycle of a 0x0008 miss: the replay misses again, `miss_cnt` increments twice for that PC, second fill succeeds.
- `rst` asserted during REQ: next cycle state=IDLE, counters=0, `IC_stall`=0. A subsequent fetch of the same PC misses (valid cleared).
